// File: rtl/timer_if.sv
// CPU byte-bus view of the timer registers (DIV/TIMA/TMA/TAC) plus the interrupt line.
// With TIMER_IRQ_HOLD_EN defined, the bus also carries irq_ack.
interface timer_if;
  logic [1:0] addr;
  logic       wr_en;
  logic [7:0] wr_data;
  logic [7:0] rd_data;
  logic       irq;
`ifdef TIMER_IRQ_HOLD_EN
  logic       irq_ack;
`endif

  modport master (
`ifdef TIMER_IRQ_HOLD_EN
    output irq_ack,
`endif
    output addr, wr_en, wr_data,
    input  rd_data, irq
  );

  modport slave (
`ifdef TIMER_IRQ_HOLD_EN
    input  irq_ack,
`endif
    input  addr, wr_en, wr_data,
    output rd_data, irq
  );
endinterface

// File: rtl/timer.sv
// Game Boy timer: prescales the divider tick into DIV and TIMA, raises irq on TIMA overflow.
// Define TIMER_IRQ_HOLD_EN to make irq a sticky level cleared by irq_ack.
module timer #(
  parameter int unsigned DIV_TICKS = 16
) (
  input logic    clock,
  input logic    reset,
  input logic    tick,
  timer_if.slave bus
);

  localparam logic [5:0] DivMask = 6'(DIV_TICKS - 1);

  logic [5:0] pre_q, pre_d;
  logic [7:0] div_q, div_d;
  logic [7:0] tima_q, tima_d;
  logic [7:0] tma_q, tma_d;
  logic [2:0] tac_q, tac_d;
  logic       irq_q, irq_d;

  logic wr_div, wr_tima, wr_tma, wr_tac;
  logic rate_hit, tima_inc, overflow;

  always_comb begin
    wr_div  = bus.wr_en && (bus.addr == 2'd0);
    wr_tima = bus.wr_en && (bus.addr == 2'd1);
    wr_tma  = bus.wr_en && (bus.addr == 2'd2);
    wr_tac  = bus.wr_en && (bus.addr == 2'd3);

    // Rate select looks at the prescaler before this tick's increment.
    unique case (tac_q[1:0])
      2'b00:   rate_hit = (pre_q == 6'd63);
      2'b01:   rate_hit = 1'b1;
      2'b10:   rate_hit = (pre_q[1:0] == 2'd3);
      default: rate_hit = (pre_q[3:0] == 4'd15);
    endcase
    tima_inc = tick && tac_q[2] && rate_hit;

    pre_d = pre_q;
    div_d = div_q;
    if (wr_div) begin
      pre_d = '0;
      div_d = '0;
    end else if (tick) begin
      pre_d = pre_q + 6'd1;
      if ((pre_q & DivMask) == DivMask) div_d = div_q + 8'd1;
    end

    tma_d = wr_tma ? bus.wr_data : tma_q;
    tac_d = wr_tac ? bus.wr_data[2:0] : tac_q;

    // A CPU write to TIMA beats a same-cycle increment and suppresses overflow.
    overflow = 1'b0;
    tima_d   = tima_q;
    if (wr_tima) begin
      tima_d = bus.wr_data;
    end else if (tima_inc) begin
      if (tima_q == 8'hff) begin
        tima_d   = tma_d;
        overflow = 1'b1;
      end else begin
        tima_d = tima_q + 8'd1;
      end
    end

`ifdef TIMER_IRQ_HOLD_EN
    irq_d = overflow || (irq_q && !bus.irq_ack);
`else
    irq_d = overflow;
`endif
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      pre_q  <= '0;
      div_q  <= '0;
      tima_q <= '0;
      tma_q  <= '0;
      tac_q  <= '0;
      irq_q  <= 1'b0;
    end else begin
      pre_q  <= pre_d;
      div_q  <= div_d;
      tima_q <= tima_d;
      tma_q  <= tma_d;
      tac_q  <= tac_d;
      irq_q  <= irq_d;
    end
  end

  always_comb begin
    unique case (bus.addr)
      2'd0:    bus.rd_data = div_q;
      2'd1:    bus.rd_data = tima_q;
      2'd2:    bus.rd_data = tma_q;
      default: bus.rd_data = {5'b11111, tac_q};
    endcase
  end

  assign bus.irq = irq_q;

endmodule

// File: tb/tb_timer.sv
// Directed self-checking bench for timer; irq expectations adapt to TIMER_IRQ_HOLD_EN.
module tb_timer;

`ifdef TIMER_IRQ_HOLD_EN
  localparam logic Hold = 1'b1;
`else
  localparam logic Hold = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset;
  logic tick;
  int   checks = 0;
  int   failures = 0;

  timer_if bus ();

  timer #(.DIV_TICKS(16)) dut (
    .clock (clock),
    .reset (reset),
    .tick  (tick),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      cyc();
    end
    tick = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    bus.addr    = a;
    bus.wr_en   = 1'b1;
    bus.wr_data = d;
    cyc();
    bus.wr_en   = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reg(input string tag, input logic [1:0] a, input logic [7:0] exp);
    bus.addr = a;
    #1;
    chk(tag, bus.rd_data, exp);
  endtask

  task automatic chk_irq(input string tag, input logic exp);
    chk(tag, {7'd0, bus.irq}, {7'd0, exp});
  endtask

  // Clears a sticky irq in hold mode; a no-op in pulse mode.
  task automatic ack_irq();
`ifdef TIMER_IRQ_HOLD_EN
    bus.irq_ack = 1'b1;
    cyc();
    bus.irq_ack = 1'b0;
    chk_irq("irq_after_ack", 1'b0);
`endif
  endtask

  initial begin
    reset       = 1'b0;
    tick        = 1'b0;
    bus.addr    = 2'd0;
    bus.wr_en   = 1'b0;
    bus.wr_data = 8'h00;
`ifdef TIMER_IRQ_HOLD_EN
    bus.irq_ack = 1'b0;
`endif

    // Reset with random bus activity
    repeat (2) begin
      tick        = 1'($urandom_range(0, 1));
      bus.addr    = 2'($urandom_range(0, 3));
      bus.wr_en   = 1'b1;
      bus.wr_data = 8'($urandom);
      cyc();
    end
    tick      = 1'b0;
    bus.wr_en = 1'b0;
    chk_reg("rst_div", 2'd0, 8'h00);
    chk_reg("rst_tima", 2'd1, 8'h00);
    chk_reg("rst_tma", 2'd2, 8'h00);
    chk_reg("rst_tac", 2'd3, 8'hf8);
    chk_irq("rst_irq", 1'b0);
    reset = 1'b1;

    // DIV counting and wrap
    ticks(16);
    chk_reg("div_16", 2'd0, 8'h01);
    ticks(4079);
    chk_reg("div_4095", 2'd0, 8'hff);
    ticks(1);
    chk_reg("div_wrap", 2'd0, 8'h00);

    // DIV write clears prescaler too
    ticks(8);
    chk_reg("div_8", 2'd0, 8'h00);
    wr(2'd0, 8'h5a);
    chk_reg("div_wr", 2'd0, 8'h00);
    ticks(15);
    chk_reg("div_wr_15", 2'd0, 8'h00);
    ticks(1);
    chk_reg("div_wr_16", 2'd0, 8'h01);

    // Overflow reload and irq pulse
    wr(2'd2, 8'hf0);
    wr(2'd1, 8'hfe);
    wr(2'd3, 8'h05);
    ticks(1);
    chk_reg("ovf_tima_ff", 2'd1, 8'hff);
    chk_irq("ovf_irq_pre", 1'b0);
    ticks(1);
    chk_irq("ovf_irq", 1'b1);
    chk_reg("ovf_reload", 2'd1, 8'hf0);
    cyc();
    chk_irq("ovf_irq_next", Hold);
    ack_irq();

    // Rates
    wr(2'd3, 8'h04);
    wr(2'd1, 8'h00);
    wr(2'd0, 8'h00);
    ticks(63);
    chk_reg("rate00_63", 2'd1, 8'h00);
    ticks(1);
    chk_reg("rate00_64", 2'd1, 8'h01);
    ticks(64);
    chk_reg("rate00_128", 2'd1, 8'h02);

    wr(2'd3, 8'h06);
    chk_reg("tac_06", 2'd3, 8'hfe);
    wr(2'd1, 8'h00);
    wr(2'd0, 8'h00);
    ticks(256);
    chk_reg("rate10_256", 2'd1, 8'h40);

    wr(2'd3, 8'h00);
    ticks(256);
    chk_reg("disabled_256", 2'd1, 8'h40);
    chk_reg("tac_00", 2'd3, 8'hf8);

    wr(2'd3, 8'h07);
    wr(2'd0, 8'h00);
    ticks(15);
    chk_reg("rate11_15", 2'd1, 8'h40);
    ticks(1);
    chk_reg("rate11_16", 2'd1, 8'h41);

    // Collision: TIMA write beats overflow
    wr(2'd3, 8'h05);
    wr(2'd1, 8'hff);
    bus.addr    = 2'd1;
    bus.wr_en   = 1'b1;
    bus.wr_data = 8'h10;
    tick        = 1'b1;
    cyc();
    tick      = 1'b0;
    bus.wr_en = 1'b0;
    chk_reg("coll_tima", 2'd1, 8'h10);
    chk_irq("coll_tima_irq", 1'b0);

    // Collision: TMA write on overflow cycle feeds the reload
    wr(2'd1, 8'hff);
    bus.addr    = 2'd2;
    bus.wr_en   = 1'b1;
    bus.wr_data = 8'h33;
    tick        = 1'b1;
    cyc();
    tick      = 1'b0;
    bus.wr_en = 1'b0;
    chk_irq("coll_tma_irq", 1'b1);
    chk_reg("coll_tma_tima", 2'd1, 8'h33);
    chk_reg("coll_tma_tma", 2'd2, 8'h33);
    cyc();
    chk_irq("coll_tma_irq_next", Hold);
    ack_irq();

    // Back-to-back overflows
    wr(2'd2, 8'hfe);
    wr(2'd1, 8'hff);
    tick = 1'b1;
    cyc();
    chk_irq("b2b_irq1", 1'b1);
    chk_reg("b2b_tima1", 2'd1, 8'hfe);
    cyc();
    chk_irq("b2b_irq2", Hold);
    chk_reg("b2b_tima2", 2'd1, 8'hff);
    cyc();
    tick = 1'b0;
    chk_irq("b2b_irq3", 1'b1);
    chk_reg("b2b_tima3", 2'd1, 8'hfe);
    cyc();
    chk_irq("b2b_irq4", Hold);
    ack_irq();

`ifdef TIMER_IRQ_HOLD_EN
    // Sticky irq held until acknowledged
    wr(2'd1, 8'hff);
    ticks(1);
    wr(2'd3, 8'h00);
    repeat (100) cyc();
    chk_irq("hold_100", 1'b1);
    bus.irq_ack = 1'b1;
    cyc();
    bus.irq_ack = 1'b0;
    chk_irq("hold_ack", 1'b0);

    // Overflow wins over same-cycle ack
    wr(2'd3, 8'h05);
    wr(2'd1, 8'hff);
    tick        = 1'b1;
    bus.irq_ack = 1'b1;
    cyc();
    tick        = 1'b0;
    bus.irq_ack = 1'b0;
    chk_irq("hold_ovf_ack", 1'b1);
    ack_irq();
`endif

    // Reset mid-irq with tick high
    wr(2'd3, 8'h05);
    wr(2'd1, 8'hff);
    tick = 1'b1;
    cyc();
    chk_irq("mid_irq", 1'b1);
    reset = 1'b0;
    cyc();
    reset = 1'b1;
    tick  = 1'b0;
    chk_irq("mid_rst_irq", 1'b0);
    chk_reg("mid_rst_div", 2'd0, 8'h00);
    chk_reg("mid_rst_tima", 2'd1, 8'h00);
    chk_reg("mid_rst_tma", 2'd2, 8'h00);
    chk_reg("mid_rst_tac", 2'd3, 8'hf8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
